axi_master_arb: RTL and testbench
=================================

// Module: axi_master_arb
// PURPOSE
//  Shares one AXI4 master port (ID-tagged, INCR) between NUM_REQ internal requesters (CPU IF / MEM).
//  Arbitrates, issues one transaction at a time, and returns read beats and write/read completion.
//  Sits between the CPU wrapper's requesters and the AXI master port feeding the bridge.
// PARAMETERS
//  NUM_REQ  2   number of requesters (index 0..NUM_REQ-1)
//  ADDR_W   32  address width
//  DATA_W   32  data width; STRB width = DATA_W/8
//  LEN_W    4   burst length field width (beats = len+1)
//  ID_W     4   AXI ID width; xID = owner index, zero-extended
// PORTS
//  ACLK        in   1               clock
//  ARESETn     in   1               synchronous reset, active-low
//  req_valid   in   [NUM_REQ]       request pending; held until req_gnt
//  req_write   in   [NUM_REQ]       1 = single-beat write, 0 = read burst
//  req_addr    in   [NUM_REQ][ADDR_W] start address
//  req_len     in   [NUM_REQ][LEN_W]  read beats-1 (ignored for writes)
//  req_wdata   in   [NUM_REQ][DATA_W] write data
//  req_wstrb   in   [NUM_REQ][DATA_W/8] byte strobes
//  req_gnt     out  [NUM_REQ]       one-cycle accept pulse; request latched this cycle
//  rsp_rdata   out  DATA_W          read beat data (shared)
//  rsp_rvalid  out  [NUM_REQ]       read beat valid to owner; always accepted
//  rsp_done    out  [NUM_REQ]       one-cycle pulse: last R beat or B response
//  rsp_err     out  1               RESP!=OKAY on current beat/B; qualified by rsp_rvalid/rsp_done
//  AW* out / AWREADY in             AXI write address channel
//  W* out / WREADY in               AXI write data channel
//  B* in / BREADY out               AXI write response channel
//  AR* out / ARREADY in             AXI read address channel
//  R* in / RREADY out               AXI read data channel
// BEHAVIOUR
//  FSM: IDLE -> AR -> R -> IDLE (reads); IDLE -> AWW -> B -> IDLE (writes). One outstanding txn.
//  IDLE: winner chosen combinationally; req_gnt[win]=1 same cycle; addr/len/data/owner registered; next AR|AWW.
//  Round-robin: search starts at last_owner+1 (mod NUM_REQ); last_owner updated on rsp_done; reset ptr -> req 0 first.
//  AR: ARVALID=1 (registered), fields stable until ARREADY; ARSIZE=3'b010, ARBURST=2'b01, ARLEN=latched len.
//  R: RREADY=1; rsp_rvalid[owner]=RVALID (combinational); RVALID&RLAST -> rsp_done[owner], IDLE.
//  AWW: AWVALID and WVALID raised together, AWLEN=0, WLAST=1; each drops after own handshake.
//   aw_done/w_done flags; both done (incl. same cycle, either order) -> B.
//  B: BREADY=1; BVALID -> rsp_done[owner], rsp_err=(BRESP!=0), IDLE.
//  RID/BID not checked (single outstanding). rsp_err: (RRESP!=0) on R beats.
//  Latency: req_valid in IDLE at t -> ARVALID/AWVALID at t+1; done -> new grant earliest next cycle.
//  Reset (any cycle, incl. mid-burst): FSM IDLE, all VALID/READY/gnt/done = 0, flags 0, ptr=NUM_REQ-1.
//  Requester deasserting req_valid before grant is legal (no grant). No grant while not IDLE.
// CONFIGURATION
//  ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins; pointer logic removed.
//  Undefined: round-robin as above.
// STRUCTURE
//  Package axi_arb_pkg: state_e {IDLE,AR,R,AWW,B}, BURST_INCR=2'b01, SIZE_WORD=3'b010, RESP_OKAY=2'b00.
//  Sub-module axi_rr_pick: one-hot winner from valid vector + pointer (fixed-prio under macro).
// TESTING
//  1 req0 read addr=0x1000 len=3, ARREADY delayed 2 cyc -> ARLEN=3, 4 rsp_rvalid[0], rsp_done[0] on 4th beat.
//  2 req0 & req1 valid same cycle, back-to-back x3 -> grants 0,1,0 (RR); with ARB_FIXED_PRIO_EN -> 0,0,0 while req0 held.
//  3 req1 write 0xDEADBEEF strb=4'b0011: WREADY before AWREADY, then same-cycle case -> single B, rsp_done[1].
//  4 BRESP=2'b10 on write / RRESP=2'b10 on beat 2 -> rsp_err=1 only on those cycles.
//  5 ARESETn low during R beat 2 of len=7 -> next cycle IDLE, RREADY=0, no rsp_done; fresh read succeeds.
//  6 RVALID gaps (1 cyc bubbles) -> rsp_rvalid mirrors RVALID exactly, no lost/duplicated beats.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// Shared types and AXI encodings for the AXI master arbiter.
// Imported by axi_rr_pick and axi_master_arb.
package axi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    AR,
    R,
    AWW,
    B
  } state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_WORD  = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // An index into a one-entry vector still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_rr_pick.sv
// One-hot winner selection from a request vector, starting after ptr.
// ARB_FIXED_PRIO_EN: lowest index always wins and ptr is ignored.
module axi_rr_pick
  import axi_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

`ifdef ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    idx = '0;
    // Walk downwards so the lowest requesting index is assigned last.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (valid[i]) idx = IDX_W'(i);
    end
  end
`else
  always_comb begin
    idx = '0;
    // Offsets scanned from farthest to nearest; the nearest requester after ptr wins.
    for (int i = NUM_REQ; i >= 1; i--) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if ((j == (int'(ptr) + i) % NUM_REQ) && valid[j]) idx = IDX_W'(j);
      end
    end
  end
`endif

  assign any   = |valid;
  assign grant = any ? (NUM_REQ'(1) << idx) : '0;

endmodule

// File: rtl/axi_master_arb.sv
// Shares one AXI4 master port between NUM_REQ requesters, one transaction at a time.
// Define ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module axi_master_arb
  import axi_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 4,
  parameter int ID_W    = 4
) (
  input  logic                              ACLK,
  input  logic                              ARESETn,

  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0]                req_write,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ-1:0][LEN_W-1:0]     req_len,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]    req_wdata,
  input  logic [NUM_REQ-1:0][DATA_W/8-1:0]  req_wstrb,
  output logic [NUM_REQ-1:0]                req_gnt,
  output logic [DATA_W-1:0]                 rsp_rdata,
  output logic [NUM_REQ-1:0]                rsp_rvalid,
  output logic [NUM_REQ-1:0]                rsp_done,
  output logic                              rsp_err,

  output logic [ID_W-1:0]                   AWID,
  output logic [ADDR_W-1:0]                 AWADDR,
  output logic [LEN_W-1:0]                  AWLEN,
  output logic [2:0]                        AWSIZE,
  output logic [1:0]                        AWBURST,
  output logic                              AWVALID,
  input  logic                              AWREADY,

  output logic [DATA_W-1:0]                 WDATA,
  output logic [DATA_W/8-1:0]               WSTRB,
  output logic                              WLAST,
  output logic                              WVALID,
  input  logic                              WREADY,

  input  logic [ID_W-1:0]                   BID,
  input  logic [1:0]                        BRESP,
  input  logic                              BVALID,
  output logic                              BREADY,

  output logic [ID_W-1:0]                   ARID,
  output logic [ADDR_W-1:0]                 ARADDR,
  output logic [LEN_W-1:0]                  ARLEN,
  output logic [2:0]                        ARSIZE,
  output logic [1:0]                        ARBURST,
  output logic                              ARVALID,
  input  logic                              ARREADY,

  input  logic [ID_W-1:0]                   RID,
  input  logic [DATA_W-1:0]                 RDATA,
  input  logic [1:0]                        RRESP,
  input  logic                              RLAST,
  input  logic                              RVALID,
  output logic                              RREADY
);

  localparam int IDX_W = idx_width(NUM_REQ);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      owner_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [LEN_W-1:0]      len_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W/8-1:0]   wstrb_q;
  logic                  aw_done_q, w_done_q;
  logic [IDX_W-1:0]      ptr;
  logic [NUM_REQ-1:0]    pick_grant;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_any;
  logic [NUM_REQ-1:0]    owner_oh;
  logic                  accept;

  // Only one transaction is ever outstanding, so response IDs carry no information.
  logic unused_ids;
  assign unused_ids = ^{RID, BID};

  axi_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign accept   = (state_q == IDLE) && pick_any && ARESETn;
  assign owner_oh = NUM_REQ'(1) << owner_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first, so no path through the case leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      IDLE: if (pick_any) state_d = req_write[pick_idx] ? AWW : AR;
      AR:   if (ARREADY) state_d = R;
      R:    if (RVALID && RLAST) state_d = IDLE;
      AWW:  if ((aw_done_q || AWREADY) && (w_done_q || WREADY)) state_d = B;
      B:    if (BVALID) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: payload registers carry no reset; they are loaded on every grant before being read.
  always_ff @(posedge ACLK) begin
    if (accept) begin
      owner_q <= pick_idx;
      addr_q  <= req_addr[pick_idx];
      len_q   <= req_len[pick_idx];
      wdata_q <= req_wdata[pick_idx];
      wstrb_q <= req_wstrb[pick_idx];
    end
  end

  // AW and W complete independently; the flags remember which one already handshook.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else if (state_q == AWW) begin
      if (AWREADY) aw_done_q <= 1'b1;
      if (WREADY)  w_done_q  <= 1'b1;
    end else begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end
  end

`ifdef ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [IDX_W-1:0] ptr_q;

  // Resetting to the last index makes requester 0 the first to be considered.
  always_ff @(posedge ACLK) begin
    if (!ARESETn)       ptr_q <= IDX_W'(NUM_REQ - 1);
    else if (|rsp_done) ptr_q <= owner_q;
  end

  assign ptr = ptr_q;
`endif

  always_comb begin
    req_gnt    = '0;
    rsp_rvalid = '0;
    rsp_done   = '0;
    rsp_err    = 1'b0;
    ARVALID    = 1'b0;
    AWVALID    = 1'b0;
    WVALID     = 1'b0;
    RREADY     = 1'b0;
    BREADY     = 1'b0;
    case (state_q)
      IDLE: if (accept) req_gnt = pick_grant;
      AR:   ARVALID = 1'b1;
      R: begin
        RREADY  = 1'b1;
        rsp_err = (RRESP != RESP_OKAY);
        if (RVALID) rsp_rvalid = owner_oh;
        if (RVALID && RLAST) rsp_done = owner_oh;
      end
      AWW: begin
        AWVALID = !aw_done_q;
        WVALID  = !w_done_q;
      end
      B: begin
        BREADY  = 1'b1;
        rsp_err = (BRESP != RESP_OKAY);
        if (BVALID) rsp_done = owner_oh;
      end
      default: ;
    endcase
  end

  assign rsp_rdata = RDATA;

  assign ARID    = ID_W'(owner_q);
  assign ARADDR  = addr_q;
  assign ARLEN   = len_q;
  assign ARSIZE  = SIZE_WORD;
  assign ARBURST = BURST_INCR;

  assign AWID    = ID_W'(owner_q);
  assign AWADDR  = addr_q;
  assign AWLEN   = '0;
  assign AWSIZE  = SIZE_WORD;
  assign AWBURST = BURST_INCR;

  assign WDATA   = wdata_q;
  assign WSTRB   = wstrb_q;
  assign WLAST   = 1'b1;

endmodule

// File: tb/tb_axi_master_arb.sv
// Directed self-checking bench for axi_master_arb with a response scoreboard.
// Honours ARB_FIXED_PRIO_EN when computing expected grant order.
module tb_axi_master_arb;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int LEN_W   = 4;
  localparam int ID_W    = 4;

  typedef struct {
    int          owner;
    logic [31:0] data;
    logic        err;
  } beat_t;

  typedef struct {
    int   owner;
    logic err;
  } done_t;

  logic                              ACLK = 1'b0;
  logic                              ARESETn;
  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ-1:0]                req_write;
  logic [NUM_REQ-1:0][ADDR_W-1:0]    req_addr;
  logic [NUM_REQ-1:0][LEN_W-1:0]     req_len;
  logic [NUM_REQ-1:0][DATA_W-1:0]    req_wdata;
  logic [NUM_REQ-1:0][DATA_W/8-1:0]  req_wstrb;
  logic [NUM_REQ-1:0]                req_gnt;
  logic [DATA_W-1:0]                 rsp_rdata;
  logic [NUM_REQ-1:0]                rsp_rvalid;
  logic [NUM_REQ-1:0]                rsp_done;
  logic                              rsp_err;
  logic [ID_W-1:0]                   AWID, ARID, BID, RID;
  logic [ADDR_W-1:0]                 AWADDR, ARADDR;
  logic [LEN_W-1:0]                  AWLEN, ARLEN;
  logic [2:0]                        AWSIZE, ARSIZE;
  logic [1:0]                        AWBURST, ARBURST, BRESP, RRESP;
  logic                              AWVALID, AWREADY, WLAST, WVALID, WREADY;
  logic                              BVALID, BREADY, ARVALID, ARREADY;
  logic                              RLAST, RVALID, RREADY;
  logic [DATA_W-1:0]                 WDATA, RDATA;
  logic [DATA_W/8-1:0]               WSTRB;

  int    checks = 0;
  int    errors = 0;
  int    model_last;
  beat_t beat_q[$];
  done_t done_q[$];

  axi_master_arb #(
    .NUM_REQ (NUM_REQ), .ADDR_W (ADDR_W), .DATA_W (DATA_W), .LEN_W (LEN_W), .ID_W (ID_W)
  ) dut (
    .ACLK (ACLK), .ARESETn (ARESETn),
    .req_valid (req_valid), .req_write (req_write), .req_addr (req_addr), .req_len (req_len),
    .req_wdata (req_wdata), .req_wstrb (req_wstrb), .req_gnt (req_gnt),
    .rsp_rdata (rsp_rdata), .rsp_rvalid (rsp_rvalid), .rsp_done (rsp_done), .rsp_err (rsp_err),
    .AWID (AWID), .AWADDR (AWADDR), .AWLEN (AWLEN), .AWSIZE (AWSIZE), .AWBURST (AWBURST),
    .AWVALID (AWVALID), .AWREADY (AWREADY),
    .WDATA (WDATA), .WSTRB (WSTRB), .WLAST (WLAST), .WVALID (WVALID), .WREADY (WREADY),
    .BID (BID), .BRESP (BRESP), .BVALID (BVALID), .BREADY (BREADY),
    .ARID (ARID), .ARADDR (ARADDR), .ARLEN (ARLEN), .ARSIZE (ARSIZE), .ARBURST (ARBURST),
    .ARVALID (ARVALID), .ARREADY (ARREADY),
    .RID (RID), .RDATA (RDATA), .RRESP (RRESP), .RLAST (RLAST), .RVALID (RVALID), .RREADY (RREADY)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge ACLK);
    #1;
  endtask

  function automatic int model_pick(input logic [NUM_REQ-1:0] mask, input int last);
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < NUM_REQ; i++) if (mask[i]) return i;
`else
    for (int i = 1; i <= NUM_REQ; i++) if (mask[(last + i) % NUM_REQ]) return (last + i) % NUM_REQ;
`endif
    return -1;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input int i);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Scoreboard: every beat/done the DUT emits must match the oldest expectation.
  always @(negedge ACLK) begin : mon
    beat_t b;
    done_t d;
    if (ARESETn === 1'b1) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rsp_rvalid[i]) begin
          if (beat_q.size() == 0) check("unexpected_beat", 64'(i), 64'hffff);
          else begin
            b = beat_q.pop_front();
            check("beat_owner", 64'(i), 64'(b.owner));
            check("beat_data", 64'(rsp_rdata), 64'(b.data));
            check("beat_err", 64'(rsp_err), 64'(b.err));
          end
        end
        if (rsp_done[i]) begin
          if (done_q.size() == 0) check("unexpected_done", 64'(i), 64'hffff);
          else begin
            d = done_q.pop_front();
            check("done_owner", 64'(i), 64'(d.owner));
            check("done_err", 64'(rsp_err), 64'(d.err));
          end
        end
      end
    end
  end

  task automatic do_reset();
    ARESETn   = 1'b0;
    req_valid = '0;
    repeat (2) cyc();
    @(negedge ACLK);
    check("rst_ctrl", {ARVALID, AWVALID, WVALID, RREADY, BREADY}, 5'b0);
    check("rst_rsp", {req_gnt, rsp_done, rsp_rvalid}, '0);
    cyc();
    ARESETn    = 1'b1;
    model_last = NUM_REQ - 1;
  endtask

  task automatic do_read(input logic [NUM_REQ-1:0] mask, input logic [31:0] addr, input int len,
                         input int ar_delay, input bit gaps, input int err_beat, input int abort_beat);
    int          win;
    logic [31:0] d;
    win = model_pick(mask, model_last);
    for (int i = 0; i < NUM_REQ; i++) begin
      req_addr[i] = addr + 32'(i * 256);
      req_len[i]  = LEN_W'(len);
    end
    req_write = '0;
    req_valid = mask;
    @(negedge ACLK);
    check("rd_gnt", req_gnt, onehot(win));
    cyc();
    req_valid[win] = 1'b0;
    for (int k = 0; k < ar_delay; k++) begin
      @(negedge ACLK);
      check("arvalid_wait", ARVALID, 1);
      check("gnt_busy", req_gnt, 0);
      cyc();
    end
    ARREADY = 1'b1;
    @(negedge ACLK);
    check("arvalid", ARVALID, 1);
    check("araddr", ARADDR, addr + 32'(win * 256));
    check("arlen", ARLEN, len);
    check("arid", ARID, win);
    check("arsize_burst", {ARSIZE, ARBURST}, 5'b010_01);
    cyc();
    ARREADY = 1'b0;
    for (int b = 0; b <= len; b++) begin
      if (gaps && b > 0) begin
        RVALID = 1'b0;
        @(negedge ACLK);
        check("rready_gap", RREADY, 1);
        cyc();
      end
      d      = $urandom;
      RDATA  = d;
      RRESP  = (b == err_beat) ? 2'b10 : 2'b00;
      RLAST  = (b == len);
      RVALID = 1'b1;
      if (b == abort_beat) begin
        ARESETn = 1'b0;
        cyc();
        @(negedge ACLK);
        check("abort_rready", RREADY, 0);
        check("abort_rsp", {rsp_rvalid, rsp_done}, '0);
        check("abort_arvalid", ARVALID, 0);
        cyc();
        ARESETn    = 1'b1;
        RVALID     = 1'b0;
        RLAST      = 1'b0;
        model_last = NUM_REQ - 1;
        return;
      end
      beat_q.push_back('{owner: win, data: d, err: (b == err_beat)});
      if (b == len) done_q.push_back('{owner: win, err: 1'b0});
      @(negedge ACLK);
      check("rready", RREADY, 1);
      cyc();
    end
    RVALID     = 1'b0;
    RLAST      = 1'b0;
    RRESP      = 2'b00;
    model_last = win;
  endtask

  task automatic do_write(input logic [NUM_REQ-1:0] mask, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb,
                          input bit same_cycle, input logic [1:0] bresp);
    int win;
    win = model_pick(mask, model_last);
    for (int i = 0; i < NUM_REQ; i++) begin
      req_addr[i]  = addr + 32'(i * 256);
      req_wdata[i] = data;
      req_wstrb[i] = strb;
    end
    req_write = '1;
    req_valid = mask;
    @(negedge ACLK);
    check("wr_gnt", req_gnt, onehot(win));
    cyc();
    req_valid[win] = 1'b0;
    WREADY         = 1'b1;
    AWREADY        = same_cycle;
    @(negedge ACLK);
    check("aw_w_valid", {AWVALID, WVALID}, 2'b11);
    check("awaddr", AWADDR, addr + 32'(win * 256));
    check("awlen_id", {AWLEN, AWID}, {4'd0, 4'(win)});
    check("wdata", WDATA, data);
    check("wstrb_wlast", {WSTRB, WLAST}, {strb, 1'b1});
    cyc();
    WREADY = 1'b0;
    if (!same_cycle) begin
      AWREADY = 1'b1;
      @(negedge ACLK);
      check("w_dropped", {AWVALID, WVALID}, 2'b10);
      cyc();
    end
    AWREADY = 1'b0;
    @(negedge ACLK);
    check("b_wait", {BREADY, AWVALID, WVALID, |rsp_done}, 4'b1000);
    cyc();
    BVALID = 1'b1;
    BRESP  = bresp;
    done_q.push_back('{owner: win, err: (bresp != 2'b00)});
    @(negedge ACLK);
    check("bready", BREADY, 1);
    cyc();
    BVALID     = 1'b0;
    BRESP      = 2'b00;
    model_last = win;
  endtask

  initial begin
    req_valid = '0; req_write = '0; req_addr = '0; req_len = '0; req_wdata = '0; req_wstrb = '0;
    AWREADY = 0; WREADY = 0; BID = '0; BRESP = '0; BVALID = 0; ARREADY = 0;
    RID = '0; RDATA = '0; RRESP = '0; RLAST = 0; RVALID = 0;
    ARESETn = 1'b0;
    cyc();
    do_reset();

    // Read burst with delayed ARREADY
    do_read(2'b01, 32'h1000, 3, 2, 1'b0, -1, -1);

    // Both requesters pending: three back-to-back grants from reset
    do_reset();
    do_read(2'b11, 32'h2000, 0, 0, 1'b0, -1, -1);
    do_read(2'b11, 32'h3000, 1, 0, 1'b0, -1, -1);
    do_read(2'b11, 32'h4000, 0, 1, 1'b0, -1, -1);

    // Writes: W before AW, then both in one cycle; then an error response
    do_write(2'b10, 32'h5000, 32'hDEADBEEF, 4'b0011, 1'b0, 2'b00);
    do_write(2'b10, 32'h5100, 32'h12345678, 4'b1111, 1'b1, 2'b00);
    do_write(2'b01, 32'h5200, 32'hCAFEF00D, 4'b1000, 1'b1, 2'b10);

    // Error on one read beat only
    do_read(2'b10, 32'h6000, 3, 0, 1'b0, 2, -1);

    // Reset during a burst, then a fresh read
    do_read(2'b01, 32'h7000, 7, 0, 1'b0, -1, 2);
    do_read(2'b01, 32'h7800, 2, 0, 1'b0, -1, -1);

    // RVALID bubbles between beats
    do_read(2'b10, 32'h8000, 4, 1, 1'b1, -1, -1);

    repeat (2) cyc();
    check("beats_drained", beat_q.size(), 0);
    check("dones_drained", done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
